// File: rtl/pinkball_pkg.sv
// Shared types and constants for the pink ball sprite path.
// Optional animation build: define PINKBALL_ANIM_EN.
package pinkball_pkg;

  typedef logic [9:0] coord_t;

  localparam int         DEF_SPR_W      = 16;
  localparam int         DEF_SPR_H      = 16;
  localparam logic [7:0] DEF_TRANSP_IDX = 8'h00;
  localparam int         H_ACTIVE       = 640;
  localparam int         V_ACTIVE       = 480;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pinkball_anim_ctr.sv
// Animation divider and frame counter, stepped by frame_start.
// Only instantiated when PINKBALL_ANIM_EN is defined.
module pinkball_anim_ctr
  import pinkball_pkg::*;
#(
  parameter int ANIM_FRAMES = 4,
  parameter int ANIM_DIV    = 8
)(
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_start,
  output logic [cw(ANIM_FRAMES)-1:0] frame
);

  localparam int FRM_W = cw(ANIM_FRAMES);
  localparam int DIV_W = cw(ANIM_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(ANIM_FRAMES - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div   <= '0;
      frame <= '0;
    end else if (frame_start) begin
      if (div == DIV_LAST) begin
        div   <= '0;
        frame <= (frame == FRM_LAST) ? '0 : frame + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pinkball_sprite_fetch.sv
// Pink ball sprite fetch: box test, ROM address, 3-cycle index pipe.
// Optional animation build: define PINKBALL_ANIM_EN.
module pinkball_sprite_fetch
  import pinkball_pkg::*;
#(
  parameter int         SPR_W       = DEF_SPR_W,
  parameter int         SPR_H       = DEF_SPR_H,
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] TRANSP_IDX  = DEF_TRANSP_IDX,
  parameter int         ANIM_FRAMES = 4,
  parameter int         ANIM_DIV    = 8
)(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [9:0]        ball_x,
  input  logic [9:0]        ball_y,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              draw_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        pix_index,
  output logic              pix_hit,
  output logic              pix_valid
);

  localparam int XS    = $clog2(SPR_W);
  localparam int FRM_W = cw(ANIM_FRAMES);
  localparam int FRM_SZ = SPR_W * SPR_H;

  localparam logic [10:0] SW = 11'(SPR_W);
  localparam logic [10:0] SH = 11'(SPR_H);

  coord_t px;
  coord_t py;

  logic [FRM_W-1:0]  frame;
  logic [10:0]       x11, y11, px11, py11;
  logic [10:0]       dx, dy;
  logic              in_box;
  logic [ADDR_W-1:0] addr_nx;

  logic s1_valid, s1_in;
  logic s2_valid, s2_in;

`ifdef PINKBALL_ANIM_EN
  pinkball_anim_ctr #(
    .ANIM_FRAMES(ANIM_FRAMES),
    .ANIM_DIV   (ANIM_DIV)
  ) u_anim (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .frame      (frame)
  );
`else
  logic unused_anim_div;
  assign unused_anim_div = ^ANIM_DIV;
  assign frame = '0;
`endif

  // 11-bit compares keep px+SPR_W past 1023 from wrapping
  always_comb begin
    x11  = {1'b0, draw_x};
    y11  = {1'b0, draw_y};
    px11 = {1'b0, px};
    py11 = {1'b0, py};
    dx   = x11 - px11;
    dy   = y11 - py11;
    in_box = draw_valid
           && (x11 >= px11) && (x11 < px11 + SW)
           && (y11 >= py11) && (y11 < py11 + SH);
    addr_nx = ADDR_W'(32'(frame) * FRM_SZ)
            + ADDR_W'(32'(dy) << XS)
            + ADDR_W'(dx);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      px        <= '0;
      py        <= '0;
      rom_addr  <= '0;
      s1_valid  <= 1'b0;
      s1_in     <= 1'b0;
      s2_valid  <= 1'b0;
      s2_in     <= 1'b0;
      pix_valid <= 1'b0;
      pix_index <= '0;
      pix_hit   <= 1'b0;
    end else begin
      if (frame_start) begin
        px <= ball_x;
        py <= ball_y;
      end
      s1_valid <= draw_valid;
      s1_in    <= in_box;
      if (in_box) rom_addr <= addr_nx;
      s2_valid  <= s1_valid;
      s2_in     <= s1_in;
      pix_valid <= s2_valid;
      pix_index <= s2_in ? rom_data : TRANSP_IDX;
      pix_hit   <= s2_in && (rom_data != TRANSP_IDX);
    end
  end

endmodule

// File: tb/tb_pinkball_sprite_fetch.sv
// Scoreboard bench for pinkball_sprite_fetch with a behavioural ROM.
// Build with PINKBALL_ANIM_EN defined to cover the animation counter.
module tb_pinkball_sprite_fetch;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       draw_valid = 1'b0;
  logic [9:0] ball_x = '0;
  logic [9:0] ball_y = '0;
  logic [9:0] draw_x = '0;
  logic [9:0] draw_y = '0;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] pix_index;
  logic       pix_hit;
  logic       pix_valid;

  pinkball_sprite_fetch dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_valid (draw_valid),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_index  (pix_index),
    .pix_hit    (pix_hit),
    .pix_valid  (pix_valid)
  );

  always #5 Clk = ~Clk;

  logic [7:0] rom [1024];
  always @(posedge Clk) rom_data <= rom[rom_addr];

  int compared = 0;
  int mismatched = 0;
  int cyc_n = 0;
  always @(posedge Clk) cyc_n <= cyc_n + 1;

  // reference state: position, frame_start count, last in-box address
  int mpx = 0;
  int mpy = 0;
  int pulses = 0;
  int maddr = 0;

  typedef struct {
    int         cyc;
    logic [7:0] idx;
    logic       hit;
  } exp_t;
  exp_t q[$];

  function automatic int mframe();
`ifdef PINKBALL_ANIM_EN
    return (pulses / 8) % 4;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)",
               name, act, req, cyc_n);
    end
  endtask

  task automatic cyc(input logic rst, input logic v, input logic fs,
                     input int x, input int y, input int bx, input int by);
    bit   inb;
    int   a;
    exp_t e;
    Reset       = rst;
    draw_valid  = v;
    frame_start = fs;
    draw_x      = x[9:0];
    draw_y      = y[9:0];
    ball_x      = bx[9:0];
    ball_y      = by[9:0];
    inb = v && x >= mpx && x < mpx + 16 && y >= mpy && y < mpy + 16;
    a = 0;
    if (inb) a = (mframe() * 256 + (y - mpy) * 16 + (x - mpx)) % 1024;
    if (rst) begin
      q.delete();
      mpx = 0; mpy = 0; pulses = 0; maddr = 0;
    end else begin
      if (v) begin
        e.cyc = cyc_n + 3;
        e.idx = inb ? rom[a] : 8'h00;
        e.hit = inb && rom[a] != 8'h00;
        q.push_back(e);
      end
      if (inb) maddr = a;
      if (fs) begin
        mpx = bx; mpy = by; pulses++;
      end
    end
    @(posedge Clk);
    #1;
    check("rom_addr", 32'(rom_addr), 32'(maddr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (pix_valid) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pix: pix_valid=1, required 0 (cycle %0d)",
                 cyc_n);
      end else begin
        e = q.pop_front();
        check("pix_latency", 32'(cyc_n), 32'(e.cyc));
        check("pix_index", 32'(pix_index), 32'(e.idx));
        check("pix_hit", 32'(pix_hit), 32'(e.hit));
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc_n) begin
      e = q.pop_front();
      check("pix_missing", 32'(pix_valid), 32'(1));
    end
  end

  int seen;

  initial begin
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    rom[0]   = 8'h03;
    rom[3]   = 8'h5a;
    rom[255] = 8'h21;
    rom[256] = 8'h77;

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_index", 32'(pix_index), 0);
    check("rst_pix_hit", 32'(pix_hit), 0);

    // origin, far corner, just right and just left of the box
    cyc(0, 0, 1, 0, 0, 100, 50);
    cyc(0, 1, 0, 100, 50, 0, 0);
    cyc(0, 1, 0, 115, 65, 0, 0);
    cyc(0, 1, 0, 116, 50, 0, 0);
    cyc(0, 1, 0, 99, 50, 0, 0);
    idle(4);

    // reset lands with three pixels in flight
    cyc(0, 1, 0, 100, 50, 0, 0);
    cyc(0, 1, 0, 101, 51, 0, 0);
    cyc(1, 1, 0, 102, 52, 0, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (pix_valid) seen++;
    end
    check("flush_after_reset", 32'(seen), 0);

    // right screen edge: no wrap of px+SPR_W
    cyc(0, 0, 1, 0, 0, 1020, 470);
    cyc(0, 1, 0, 1023, 470, 0, 0);
    cyc(0, 1, 0, 3, 470, 0, 0);
    cyc(0, 1, 0, 1020, 485, 0, 0);
    cyc(0, 1, 0, 1020, 486, 0, 0);
    idle(4);

    // frame_start together with a pixel
    cyc(0, 0, 1, 0, 0, 100, 50);
    cyc(0, 1, 1, 105, 55, 200, 50);
    cyc(0, 1, 0, 205, 55, 0, 0);
    cyc(0, 1, 0, 105, 55, 0, 0);
    idle(4);

    // 32 frame_start pulses with a draw at the origin after each
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 1, 0, 0, 100, 50);
      cyc(0, 1, 0, 100, 50, 0, 0);
      cyc(0, 1, 0, 107, 58, 0, 0);
    end
    idle(4);

    for (int i = 0; i < 500; i++) begin
      int x, y;
      x = (mpx + $urandom_range(0, 21) - 3) & 1023;
      y = (mpy + $urandom_range(0, 21) - 3) & 1023;
      if ($urandom_range(0, 7) == 0) begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
      end
      cyc(0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
          x, y, $urandom_range(0, 1023), $urandom_range(0, 1023));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
    check("scoreboard_drained", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pinkball_sprite_fetch.md
Name: pinkball_sprite_fetch

Overview:
- Per-pixel sprite fetch stage for the pink ball; sits directly upstream of the pink ball palette lookup.
- Compares the raster coordinate against the ball position latched at frame start, generates the sprite ROM address, and receives the 8-bit palette index from the synchronous sprite ROM.
- Outputs a pipelined, valid-qualified palette index with a hit flag; the palette stage converts that index to RGB.

Parameters:
- SPR_W, 16, sprite width in pixels (power of 2).
- SPR_H, 16, sprite height in pixels.
- ADDR_W, 10, sprite ROM address width.
- TRANSP_IDX, 8'h00, palette index treated as transparent.
- ANIM_FRAMES, 4, number of animation frames stored consecutively in the ROM.
- ANIM_DIV, 8, number of frame_start pulses per animation step.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous reset, active-high.
- frame_start  in  1  single-cycle pulse at the start of vertical blank.
- ball_x  in  10  ball top-left X coordinate; sampled only on frame_start.
- ball_y  in  10  ball top-left Y coordinate; sampled only on frame_start.
- draw_x  in  10  raster X coordinate.
- draw_y  in  10  raster Y coordinate.
- draw_valid  in  1  raster coordinate is valid this cycle.
- rom_addr  out  ADDR_W  sprite ROM address, registered.
- rom_data  in  8  ROM palette index; valid one cycle after rom_addr.
- pix_index  out  8  palette index to the palette stage.
- pix_hit  out  1  pixel is inside the sprite and not transparent.
- pix_valid  out  1  draw_valid delayed by 3 cycles.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: rom_addr=0, pix_index=0, pix_hit=0, pix_valid=0, latched position=(0,0), animation frame=0, all pipeline valid/hit bits cleared.
- Reset asserted mid-operation flushes in-flight pixels; nothing reaches the outputs after the reset cycle.

Position latch:
- On frame_start, latch ball_x/ball_y. The new value is used from the next cycle onward.
- If a draw_valid coincides with frame_start, that pixel is compared against the old position.

Stage 1 (inputs at cycle N, registered at N+1):
- dx = draw_x - px and dy = draw_y - py, computed with 11-bit unsigned math.
- in_box = draw_valid && draw_x >= px && draw_x < px+SPR_W && draw_y >= py && draw_y < py+SPR_H.
- Comparisons are 11-bit so px+SPR_W beyond 1023 neither wraps nor aliases.
- rom_addr = frame*SPR_W*SPR_H + dy*SPR_W + dx, truncated to ADDR_W. Multiplication by SPR_W is a shift.
- When not in_box, rom_addr holds its previous value.

Stage 2 (N+2):
- Carry in_box and valid bits forward; rom_data now corresponds to stage 1's address.

Output register (N+3):
- pix_valid = delayed draw_valid.
- pix_index = rom_data when in_box, else TRANSP_IDX.
- pix_hit = in_box && rom_data != TRANSP_IDX.
- Total latency is 3 cycles, with a fully pipelined throughput of 1 pixel/cycle. There is no backpressure.

Optional Feature:
- Macro: PINKBALL_ANIM_EN.
- Defined: the animation counter increments a divider on each frame_start. When the divider reaches ANIM_DIV-1 it clears and frame advances, wrapping ANIM_FRAMES-1 -> 0. Frame changes take effect on the cycle after that frame_start, so the frame is constant across a whole visible frame.
- Undefined: frame is constantly 0, the divider is absent, and ANIM_FRAMES/ANIM_DIV are unused.

Decomposition:
- pinkball_pkg: coord_t (logic [9:0]), SPR_W/SPR_H defaults, TRANSP_IDX, screen constants H_ACTIVE=640 and V_ACTIVE=480.
- One sub-module, pinkball_anim_ctr: divider plus frame counter, with inputs Clk/Reset/frame_start and output frame. Instantiated only under PINKBALL_ANIM_EN.

Test Plan:
- Reset then idle: all outputs 0. Pulse Reset mid-stream with 3 valid pixels in flight -> pix_valid stays 0 for those pixels.
- Ball at (100,50) latched on frame_start; draw (100,50) at cycle N -> rom_addr=0 at N+1. With rom_data=8'h03, at N+3: pix_valid=1, pix_hit=1, pix_index=3.
- Same ball; draw (115,65) -> rom_addr=255. Draw (116,50) and (99,50) -> pix_hit=0, pix_index=TRANSP_IDX.
- Edge case: ball at (1020,470); draw (1023,470) -> hit, rom_addr=3; draw (3,470) -> no hit (no wrap).
- frame_start coincident with draw_valid while ball_x changes 100->200: that pixel uses 100; the following pixels use 200.
- With PINKBALL_ANIM_EN: 8 frame_start pulses -> frame=1, and draw at the ball origin gives rom_addr=256. 32 pulses -> frame wraps to 0.
